// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Single-cycle codes matched on aluc[2:0]; aluc[3] is a don't-care for these six.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_LUI = 3'b110;

    // Shift codes need all four bits of aluc[3:0].
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1111;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle,
// operating on magnitudes with a final sign fix-up before writing HI/LO.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;
    logic                 wr_q, wr_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 run_div;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_tmp, div_diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        run_div   = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
        mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_tmp   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_tmp - {1'b0, opd_q};
        prod      = acc_q[2*WIDTH-1:0];
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    opd_d     = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = (b == '0);
                    acc_d     = {{(WIDTH+1){1'b0}}, a_mag};
                    cnt_d     = CW'(WIDTH);
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (run_div) begin
                    // A borrow out of the trial subtraction means the divisor did not fit.
                    acc_d = {1'b0,
                             div_diff[WIDTH] ? div_tmp[WIDTH-1:0] : div_diff[WIDTH-1:0],
                             acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            FIN: begin
                if (run_div) begin
                    // With a zero divisor the remainder naturally ends up as the dividend.
                    lo_d = dbz_q ? '1 : (neg_res_q ? -quo : quo);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -prod : prod;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        wr_d   = (state_q == FIN);
        done_d = wr_q;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational single-cycle operations plus the iterative MDU with
// its start/busy/done handshake and HI/LO result registers.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       aluc,
    input  logic             start,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [SHW-1:0] shamt;

    assign shamt = a[SHW-1:0];

    always_comb begin
        s = '0;
        if (!aluc[4]) begin
            case (aluc[2:0])
                OP_ADD:  s = a + b;
                OP_SUB:  s = a - b;
                OP_AND:  s = a & b;
                OP_OR:   s = a | b;
                OP_XOR:  s = a ^ b;
                OP_LUI:  s = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                default: begin
                    case (aluc[3:0])
                        OP_SLL:  s = b << shamt;
                        OP_SRL:  s = b >> shamt;
                        OP_SRA:  s = $signed(b) >>> shamt;
                        default: s = '0;
                    endcase
                end
            endcase
        end
    end

    assign z = (s == '0);

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clock  (clock),
        .resetn (resetn),
        .start  (start & aluc[4]),
        .op     (aluc[1:0]),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

endmodule
